// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions for the fetch queue: FSM encodings and entry sizing.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fq_state_e;

  localparam int unsigned STALL_CNT_BITS = 32;

  // One queue entry holds {pc, instruction}.
  function automatic int unsigned fq_entry_bits(input int unsigned word_bits);
    return 2 * word_bits;
  endfunction

endpackage

// File: rtl/fetch_queue_fq_fifo.sv
// Circular buffer with push, pop, clear, occupancy count and zero-when-empty head data.
module fq_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != CNT_W'(0));

  // Pointers and count; clear discards everything and wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = (count != CNT_W'(0)) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding imem read, flush/drop handling, in-order delivery.
// Optional stall counter output enabled by defining FETCH_QUEUE_STALL_CNT_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned WORD_BITWIDTH = 32,
  parameter int unsigned DEPTH         = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WORD_BITWIDTH-1:0] pc,
  input  logic                     pc_valid,
  output logic                     pc_ready,
  output logic                     imem_req,
  output logic [WORD_BITWIDTH-1:0] imem_addr,
  input  logic [WORD_BITWIDTH-1:0] imem_rdata,
  input  logic                     imem_rvalid,
  input  logic                     flush,
  output logic [WORD_BITWIDTH-1:0] inst,
  output logic [WORD_BITWIDTH-1:0] inst_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready
`ifdef FETCH_QUEUE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_BITS-1:0] stall_cnt
`endif
);

  localparam int unsigned ENTRY_W = fq_entry_bits(WORD_BITWIDTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  fq_state_e                state;
  fq_state_e                state_nx;
  logic [WORD_BITWIDTH-1:0] pend_pc;
  logic [CNT_W-1:0]         count;
  logic [ENTRY_W-1:0]       head;
  logic                     room;
  logic                     accept;
  logic                     push;
  logic                     pop;

  // Room must cover the queued entries plus the response still in flight.
  assign room     = (32'(count) + ((state == WAIT) ? 32'd1 : 32'd0)) < DEPTH;
  assign pc_ready = !flush && room && ((state == IDLE) || ((state == WAIT) && imem_rvalid));
  assign accept   = pc_valid && pc_ready;
  assign imem_req = accept;
  assign imem_addr = pc;
  assign push     = (state == WAIT) && imem_rvalid && !flush;
  assign pop      = inst_valid && inst_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pend_pc <= '0;
    end else begin
      state <= state_nx;
      if (accept) pend_pc <= pc;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = WAIT;
      WAIT: begin
        if (flush)            state_nx = imem_rvalid ? IDLE : DROP;
        else if (imem_rvalid) state_nx = accept ? WAIT : IDLE;
      end
      DROP: if (imem_rvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  fq_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data ({pend_pc, imem_rdata}),
    .pop       (pop),
    .count     (count),
    .head_data (head)
  );

  assign inst_valid = (count != CNT_W'(0));
  assign inst       = head[WORD_BITWIDTH-1:0];
  assign inst_pc    = head[ENTRY_W-1:WORD_BITWIDTH];

`ifdef FETCH_QUEUE_STALL_CNT_EN
  // Saturating count of cycles a fetch was offered but refused.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (pc_valid && !pc_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_BITS'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed table-driven bench for fetch_queue (DEPTH=2), plus latency and stall-counter sequences.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        flush;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
`ifdef FETCH_QUEUE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  fetch_queue #(.WORD_BITWIDTH(32), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .flush       (flush),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready)
`ifdef FETCH_QUEUE_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pcv;
    logic [31:0] pc;
    logic        rv;
    logic [31:0] rd;
    logic        fl;
    logic        ir;
    logic        e_prdy;
    logic        e_req;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic pv, input logic [31:0] p,
                              input logic rv, input logic [31:0] rd, input logic fl,
                              input logic ir, input logic epr, input logic erq,
                              input logic eiv, input logic [31:0] ei, input logic [31:0] eip);
    vec_t v;
    v.rst = r; v.pcv = pv; v.pc = p; v.rv = rv; v.rd = rd; v.fl = fl; v.ir = ir;
    v.e_prdy = epr; v.e_req = erq; v.e_iv = eiv; v.e_inst = ei; v.e_ipc = eip;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; pc_valid = v.pcv; pc = v.pc; imem_rvalid = v.rv;
    imem_rdata = v.rd; flush = v.fl; inst_ready = v.ir;
  endtask

  task automatic tick(input vec_t v);
    @(posedge clk); #1;
    drive(v);
  endtask

  task automatic idle_in();
    tick(mk(0,0,32'h0,0,32'h0,0,0, 0,0,0,32'h0,32'h0));
  endtask

  initial begin
    bit seen;
    drive(mk(1,0,32'h0,0,32'h0,0,0, 0,0,0,32'h0,32'h0));
    repeat (2) @(posedge clk);

    //        rst pcv pc          rv rd           fl ir | prdy req iv inst         ipc
    // basic fetch
    vecs.push_back(mk(0,0,32'h000,0,32'h0       ,0,0, 1,0,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,1,32'h000,0,32'h0       ,0,0, 1,1,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,0,32'h000,1,32'h13      ,0,0, 1,0,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,0,32'h000,0,32'h0       ,0,0, 1,0,1,32'h13      ,32'h000));
    vecs.push_back(mk(0,0,32'h000,0,32'h0       ,0,1, 1,0,1,32'h13      ,32'h000));
    vecs.push_back(mk(0,0,32'h000,0,32'h0       ,0,0, 1,0,0,32'h0       ,32'h000));
    // back-to-back fetches into a full queue, inst_ready low
    vecs.push_back(mk(0,1,32'h000,0,32'h0       ,0,0, 1,1,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,1,32'h004,1,32'hA0      ,0,0, 1,1,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,1,32'h008,1,32'hA4      ,0,0, 0,0,1,32'hA0      ,32'h000));
    vecs.push_back(mk(0,1,32'h008,0,32'h0       ,0,0, 0,0,1,32'hA0      ,32'h000));
    vecs.push_back(mk(0,1,32'h008,0,32'h0       ,0,1, 0,0,1,32'hA0      ,32'h000));
    vecs.push_back(mk(0,1,32'h008,0,32'h0       ,0,0, 1,1,1,32'hA4      ,32'h004));
    vecs.push_back(mk(0,0,32'h000,1,32'hA8      ,0,0, 0,0,1,32'hA4      ,32'h004));
    vecs.push_back(mk(0,0,32'h000,0,32'h0       ,0,1, 0,0,1,32'hA4      ,32'h004));
    vecs.push_back(mk(0,0,32'h000,0,32'h0       ,0,1, 1,0,1,32'hA8      ,32'h008));
    vecs.push_back(mk(0,0,32'h000,0,32'h0       ,0,0, 1,0,0,32'h0       ,32'h000));
    // flush in WAIT, late response dropped
    vecs.push_back(mk(0,1,32'h100,0,32'h0       ,0,0, 1,1,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,0,32'h000,0,32'h0       ,1,0, 0,0,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,0,32'h000,0,32'h0       ,0,0, 0,0,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,1,32'h200,1,32'hDEADBEEF,0,0, 0,0,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,0,32'h000,0,32'h0       ,0,0, 1,0,0,32'h0       ,32'h000));
    // flush coinciding with the response
    vecs.push_back(mk(0,1,32'h300,0,32'h0       ,0,0, 1,1,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,1,32'h304,1,32'h55      ,1,0, 0,0,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,0,32'h000,0,32'h0       ,0,0, 1,0,0,32'h0       ,32'h000));
    // streaming with simultaneous push/pop across pointer wrap
    vecs.push_back(mk(0,1,32'h010,0,32'h0       ,0,0, 1,1,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,1,32'h014,1,32'hB0      ,0,0, 1,1,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,1,32'h018,1,32'hB4      ,0,1, 0,0,1,32'hB0      ,32'h010));
    vecs.push_back(mk(0,1,32'h018,0,32'h0       ,0,1, 1,1,1,32'hB4      ,32'h014));
    vecs.push_back(mk(0,0,32'h000,1,32'hB8      ,0,1, 1,0,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,0,32'h000,0,32'h0       ,0,1, 1,0,1,32'hB8      ,32'h018));
    vecs.push_back(mk(0,0,32'h000,0,32'h0       ,0,0, 1,0,0,32'h0       ,32'h000));
    // rst with an entry queued and WAIT active, late rvalid ignored
    vecs.push_back(mk(0,1,32'h040,0,32'h0       ,0,0, 1,1,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,1,32'h044,1,32'hC0      ,0,0, 1,1,0,32'h0       ,32'h000));
    vecs.push_back(mk(1,0,32'h000,0,32'h0       ,1,1, 0,0,1,32'hC0      ,32'h040));
    vecs.push_back(mk(0,0,32'h000,1,32'hC4      ,0,0, 1,0,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,0,32'h000,0,32'h0       ,0,0, 1,0,0,32'h0       ,32'h000));
    // rst beats an accept in the same cycle
    vecs.push_back(mk(1,1,32'h050,0,32'h0       ,0,0, 1,1,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,0,32'h000,1,32'h77      ,0,0, 1,0,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,0,32'h000,0,32'h0       ,0,0, 1,0,0,32'h0       ,32'h000));
    // flush in IDLE clears a queued entry
    vecs.push_back(mk(0,1,32'h060,0,32'h0       ,0,0, 1,1,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,0,32'h000,1,32'hD0      ,0,0, 1,0,0,32'h0       ,32'h000));
    vecs.push_back(mk(0,1,32'h064,0,32'h0       ,1,0, 0,0,1,32'hD0      ,32'h060));
    vecs.push_back(mk(0,0,32'h000,0,32'h0       ,0,0, 1,0,0,32'h0       ,32'h000));

    foreach (vecs[i]) begin
      tick(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d.pc_ready", i), 32'(pc_ready), 32'(vecs[i].e_prdy));
      check($sformatf("v%0d.imem_req", i), 32'(imem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) check($sformatf("v%0d.imem_addr", i), imem_addr, vecs[i].pc);
      check($sformatf("v%0d.inst_valid", i), 32'(inst_valid), 32'(vecs[i].e_iv));
      check($sformatf("v%0d.inst", i), inst, vecs[i].e_inst);
      check($sformatf("v%0d.inst_pc", i), inst_pc, vecs[i].e_ipc);
    end

    // Three-cycle memory latency: pc_ready held low while waiting.
    tick(mk(0,1,32'h080,0,32'h0,0,0, 0,0,0,32'h0,32'h0));
    @(negedge clk);
    check("lat.req", 32'(imem_req), 32'd1);
    repeat (2) begin
      idle_in();
      @(negedge clk);
      check("lat.wait_prdy", 32'(pc_ready), 32'd0);
    end
    tick(mk(0,0,32'h0,1,32'hE0,0,0, 0,0,0,32'h0,32'h0));
    idle_in();
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (inst_valid) seen = 1'b1;
      else idle_in();
    end
    check("lat.timeout", 32'(seen), 32'd1);
    check("lat.inst", inst, 32'hE0);
    check("lat.inst_pc", inst_pc, 32'h080);
    tick(mk(0,0,32'h0,0,32'h0,0,1, 0,0,0,32'h0,32'h0));
    idle_in();
    @(negedge clk);
    check("lat.drain", 32'(inst_valid), 32'd0);

`ifdef FETCH_QUEUE_STALL_CNT_EN
    tick(mk(1,0,32'h0,0,32'h0,0,0, 0,0,0,32'h0,32'h0));
    idle_in();
    @(negedge clk);
    check("stall.reset", stall_cnt, 32'd0);
    tick(mk(0,1,32'h0,0,32'h0,0,0, 0,0,0,32'h0,32'h0));
    tick(mk(0,0,32'h0,1,32'h1,0,0, 0,0,0,32'h0,32'h0));
    tick(mk(0,1,32'h4,0,32'h0,0,0, 0,0,0,32'h0,32'h0));
    tick(mk(0,0,32'h0,1,32'h2,0,0, 0,0,0,32'h0,32'h0));
    repeat (5) tick(mk(0,1,32'h8,0,32'h0,0,0, 0,0,0,32'h0,32'h0));
    idle_in();
    @(negedge clk);
    check("stall.cnt", stall_cnt, 32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
